// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer.
// Drives one shared round datapath: an initial AddRoundKey, NR-1 full rounds,
// and a final round with MixColumns bypassed.
// The block is framed by a valid/ready handshake on the input and on the output.
module aes_round_ctrl #(
    parameter int NR = 10,  // number of rounds, 2..14
    parameter int RW = 4    // round counter width, 2**RW > NR
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          load_init,
    output logic          state_en,
    output logic          key_step,
    output logic          mix_bypass,
    output logic [RW-1:0] round_idx,
    output logic [7:0]    rcon,
    output logic          busy
);

    // Reject parameter sets that cannot sequence a legal AES schedule
    if (NR < 2 || NR > 14 || (2 ** RW) <= NR) begin : g_param_check
        $error("aes_round_ctrl: illegal NR/RW combination");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [7:0]    rcon_q,  rcon_d;
    logic          accept;

    // GF(2^8) doubling, used to step the round constant
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Input handshake: a new block is taken when idle, or from HOLD in the
    // same cycle the result is consumed, so back-to-back blocks need no bubble
    always_comb begin
        in_ready = ~abort & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
        accept   = in_valid & in_ready;
    end

    // Next state, round counter and round constant. Abort overrides everything
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_INIT;
            end
            S_INIT: begin
                state_d = (NR == 1) ? S_FINAL : S_ROUND;
                round_d = RW'(1);
                rcon_d  = 8'h01;
            end
            S_ROUND: begin
                round_d = round_q + 1'b1;
                rcon_d  = xtime(rcon_q);
                if (round_q == RW'(NR - 1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // Counters stay at the final values while the result is held
                if (out_ready) begin
                    state_d = accept ? S_INIT : S_IDLE;
                    round_d = '0;
                    rcon_d  = 8'h01;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
                rcon_d  = 8'h01;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            round_d = '0;
            rcon_d  = 8'h01;
        end
    end

    // State, round counter and Rcon registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    // Moore strobes decoded from the registered state only
    always_comb begin
        load_init  = (state_q == S_INIT);
        state_en   = (state_q == S_ROUND) | (state_q == S_FINAL);
        key_step   = (state_q == S_ROUND) | (state_q == S_FINAL);
        mix_bypass = (state_q == S_FINAL);
        out_valid  = (state_q == S_HOLD);
        busy       = (state_q == S_INIT) | (state_q == S_ROUND) | (state_q == S_FINAL);
        round_idx  = round_q;
        rcon       = rcon_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: directed scenarios on NR=10 and NR=14
// instances, followed by random traffic checked against a cycle-age model.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

    logic       a_in_ready, a_out_valid, a_load_init, a_state_en, a_key_step, a_mix_bypass, a_busy;
    logic [3:0] a_round_idx;
    logic [7:0] a_rcon;
    logic       b_in_ready, b_out_valid, b_load_init, b_state_en, b_key_step, b_mix_bypass, b_busy;
    logic [3:0] b_round_idx;
    logic [7:0] b_rcon;

    int errors = 0;
    int checks = 0;

    // Round constants for rounds 1..14, as listed for AES
    localparam logic [7:0] RC [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .RW(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .load_init(a_load_init),
        .state_en(a_state_en), .key_step(a_key_step), .mix_bypass(a_mix_bypass),
        .round_idx(a_round_idx), .rcon(a_rcon), .busy(a_busy));

    aes_round_ctrl #(.NR(14), .RW(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .load_init(b_load_init),
        .state_en(b_state_en), .key_step(b_key_step), .mix_bypass(b_mix_bypass),
        .round_idx(b_round_idx), .rcon(b_rcon), .busy(b_busy));

    logic [18:0] va, vb;
    assign va = {a_in_ready, a_load_init, a_state_en, a_key_step, a_mix_bypass, a_out_valid, a_busy, a_rcon, a_round_idx};
    assign vb = {b_in_ready, b_load_init, b_state_en, b_key_step, b_mix_bypass, b_out_valid, b_busy, b_rcon, b_round_idx};

    // Model: age = cycles since the block was accepted (0 = idle, NR+2 = holding result)
    function automatic logic [18:0] model_out(input int age, input int nr, input bit ab, input bit ordy);
        int  hold = nr + 2;
        bit  ir   = !ab && (age == 0 || (age == hold && ordy));
        bit  li   = (age == 1);
        bit  se   = (age >= 2 && age <= nr + 1);
        bit  mb   = (age == nr + 1);
        bit  ov   = (age == hold);
        bit  bz   = (age >= 1 && age <= nr + 1);
        int  r    = (age <= 1) ? 0 : ((age <= nr + 1) ? age - 1 : nr);
        logic [7:0] rc = (age >= 2) ? RC[r - 1] : 8'h01;
        return {ir, li, se, se, mb, ov, bz, rc, 4'(r)};
    endfunction

    function automatic int model_next(input int age, input int nr, input bit ab, input bit iv, input bit ordy);
        if (ab) return 0;
        if (age == 0) return iv ? 1 : 0;
        if (age < nr + 2) return age + 1;
        return ordy ? (iv ? 1 : 0) : age;
    endfunction

    // Apply inputs just after the falling edge; outputs are then observed mid-low-phase
    task automatic step(input bit ab, input bit iv, input bit ordy);
        @(negedge clk);
        abort = ab; in_valid = iv; out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit seen_ov;
        rst_n = 1'b0; #1;
        checks++;
        if (va !== {1'b1, 6'b0, 8'h01, 4'd0}) begin errors++; $display("FAIL reset_state: got %h expected %h", va, {1'b1, 6'b0, 8'h01, 4'd0}); end
        rst_n = 1'b1;
        step(0, 1, 0);
        for (int k = 1; k <= 6; k++) step(0, 0, 0);
        checks++;
        if (a_round_idx !== 4'd5) begin errors++; $display("FAIL reset_pre_round: got %0d expected 5", a_round_idx); end
        rst_n = 1'b0; #1;
        checks++;
        if (va !== {1'b1, 6'b0, 8'h01, 4'd0}) begin errors++; $display("FAIL reset_midblock: got %h expected %h", va, {1'b1, 6'b0, 8'h01, 4'd0}); end
        #2 rst_n = 1'b1;
        seen_ov = 0;
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 0);
            if (a_out_valid) seen_ov = 1;
        end
        checks++;
        if (seen_ov !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_after: out_valid_seen=%0d in_ready=%0d expected 0/1", seen_ov, a_in_ready); end
    endtask

    task automatic test_single();
        step(0, 1, 0);
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %0d expected 1", a_in_ready); end
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] e;
            step(0, 0, 0);
            e = {k == 1, k >= 2 && k <= 11, k == 11, k == 12};
            checks++;
            if ({a_load_init, a_key_step, a_mix_bypass, a_out_valid} !== e) begin
                errors++; $display("FAIL single_strobes k=%0d: got %b expected %b", k, {a_load_init, a_key_step, a_mix_bypass, a_out_valid}, e);
            end
            if (k >= 2 && k <= 11) begin
                checks++;
                if (a_rcon !== RC[k - 2] || a_round_idx !== 4'(k - 1)) begin
                    errors++; $display("FAIL single_rcon k=%0d: got %h/%0d expected %h/%0d", k, a_rcon, a_round_idx, RC[k - 2], k - 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0);
            checks++;
            if ({a_out_valid, a_state_en, a_in_ready} !== 3'b100) begin
                errors++; $display("FAIL backpressure_hold: got %b expected 100", {a_out_valid, a_state_en, a_in_ready});
            end
        end
        step(0, 0, 1);
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b11) begin errors++; $display("FAIL backpressure_release: got %b expected 11", {a_out_valid, a_in_ready}); end
        step(0, 0, 0);
        checks++;
        if ({a_out_valid, a_busy, a_in_ready} !== 3'b001) begin errors++; $display("FAIL backpressure_idle: got %b expected 001", {a_out_valid, a_busy, a_in_ready}); end
    endtask

    task automatic test_back_to_back();
        step(0, 1, 0);
        for (int k = 1; k <= 11; k++) step(0, 0, 0);
        step(0, 1, 1);
        checks++;
        if ({a_out_valid, a_in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_hold: got %b expected 11", {a_out_valid, a_in_ready}); end
        step(0, 0, 0);
        checks++;
        if ({a_load_init, a_out_valid, a_busy} !== 3'b101) begin errors++; $display("FAIL b2b_init: got %b expected 101", {a_load_init, a_out_valid, a_busy}); end
        for (int k = 2; k <= 11; k++) step(0, 0, 0);
        step(0, 0, 1);
        checks++;
        if (a_out_valid !== 1'b1 || a_round_idx !== 4'd10) begin errors++; $display("FAIL b2b_second: got %0d/%0d expected 1/10", a_out_valid, a_round_idx); end
        step(0, 0, 0);
    endtask

    task automatic test_abort();
        bit seen;
        step(0, 1, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0);
        step(1, 1, 0);
        checks++;
        if ({a_round_idx, a_in_ready} !== {4'd4, 1'b0}) begin errors++; $display("FAIL abort_cycle: got %0d/%0d expected 4/0", a_round_idx, a_in_ready); end
        step(1, 1, 0);
        checks++;
        if (va !== {1'b0, 6'b0, 8'h01, 4'd0}) begin errors++; $display("FAIL abort_idle: got %h expected %h", va, {1'b0, 6'b0, 8'h01, 4'd0}); end
        step(0, 0, 0);
        checks++;
        if ({a_load_init, a_busy} !== 2'b00) begin errors++; $display("FAIL abort_no_accept: got %b expected 00", {a_load_init, a_busy}); end
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            step(0, 0, 0);
            if (a_out_valid || a_busy) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %0d expected 0", seen); end
    endtask

    task automatic test_nr14();
        do_reset();
        step(0, 1, 0);
        checks++;
        if (b_in_ready !== 1'b1) begin errors++; $display("FAIL nr14_accept: got %0d expected 1", b_in_ready); end
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] e;
            step(0, 0, 0);
            e = {k == 1, k >= 2 && k <= 15, k == 15, k == 16};
            checks++;
            if ({b_load_init, b_key_step, b_mix_bypass, b_out_valid} !== e) begin
                errors++; $display("FAIL nr14_strobes k=%0d: got %b expected %b", k, {b_load_init, b_key_step, b_mix_bypass, b_out_valid}, e);
            end
            if (k >= 2 && k <= 15) begin
                checks++;
                if (b_rcon !== RC[k - 2] || b_round_idx !== 4'(k - 1)) begin
                    errors++; $display("FAIL nr14_rcon k=%0d: got %h/%0d expected %h/%0d", k, b_rcon, b_round_idx, RC[k - 2], k - 1);
                end
            end
        end
    endtask

    task automatic test_random();
        int age10 = 0, age14 = 0;
        logic [18:0] ea, eb;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit ab   = ($urandom_range(0, 19) == 0);
            bit iv   = ($urandom_range(0, 1) == 1);
            bit ordy = ($urandom_range(0, 2) == 0);
            step(ab, iv, ordy);
            ea = model_out(age10, 10, ab, ordy);
            eb = model_out(age14, 14, ab, ordy);
            checks++;
            if (va !== ea) begin errors++; $display("FAIL random_nr10 n=%0d: got %h expected %h", n, va, ea); end
            checks++;
            if (vb !== eb) begin errors++; $display("FAIL random_nr14 n=%0d: got %h expected %h", n, vb, eb); end
            age10 = model_next(age10, 10, ab, iv, ordy);
            age14 = model_next(age14, 14, ab, iv, ordy);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_nr14();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
